conv_window_scanner: RTL and testbench

- Sits directly downstream of the three-row padded line register (R/G/B row0..row2, 418 px × 8 bit each).
- Once a row triplet is loaded, it sweeps a 3×3 window across the row, one column per accepted handshake, and emits 3×3×3 (R,G,B) windows to the conv engine.
- At the end of the sweep it pulses row_done, which upstream uses as its wait_en to load the next triplet. It also counts output rows so it can flag frame end.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/win_slice.sv | 42 ++++
 rtl/conv_window_scanner.sv | 148 ++++++++++++++
 tb/tb_conv_window_scanner.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants for the convolution front end: image geometry, pixel width,
// window size and the scanner FSM state encoding.
// -----------------------------------------------------------------------------
package cnn_pkg;

  // Image geometry and pixel width
  localparam int IMG_W = 416;          // unpadded row width = windows per row
  localparam int IMG_H = 416;          // output rows per frame
  localparam int DW    = 8;            // bits per pixel
  localparam int PAD_W = IMG_W + 2;    // padded row width in pixels

  // Bytes per 3x3 window (byte k = 3*r + c)
  localparam int K = 9;

  // Scanner FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/win_slice.sv
// -----------------------------------------------------------------------------
// win_slice
// Combinational extraction of one 3x3 window from three padded row buses.
// Output byte k = 3*r + c is pixel (x + c) of row r. Pure selection.
//
// Ports:
//   row0, row1, row2 : in  PAD_W*DW  padded rows, pixel p at bits [DW*p +: DW]
//   x                : in  XW        window column (0 .. PAD_W-3)
//   win              : out K*DW      extracted window
// -----------------------------------------------------------------------------
module win_slice #(
  parameter int PAD_W = cnn_pkg::PAD_W,
  parameter int DW    = cnn_pkg::DW,
  parameter int XW    = $clog2(cnn_pkg::IMG_W)
) (
  input  logic [PAD_W*DW-1:0] row0,
  input  logic [PAD_W*DW-1:0] row1,
  input  logic [PAD_W*DW-1:0] row2,
  input  logic [XW-1:0]       x,
  output logic [cnn_pkg::K*DW-1:0] win
);
  import cnn_pkg::*;

  // Bit-index width sized to the row bus so the part-selects carry no
  // oversized index.
  localparam int IW = $clog2(PAD_W*DW);

  logic [IW-1:0] base;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    win  = '0;
    base = IW'(DW * 32'(x));
    for (int c = 0; c < 3; c++) begin
      win[DW*c     +: DW] = row0[base + IW'(DW*c) +: DW];
      win[DW*(3+c) +: DW] = row1[base + IW'(DW*c) +: DW];
      win[DW*(6+c) +: DW] = row2[base + IW'(DW*c) +: DW];
    end
  end

endmodule

// File: rtl/conv_window_scanner.sv
// -----------------------------------------------------------------------------
// conv_window_scanner
// Sweeps a 3x3 window across a loaded padded row triplet, one column per
// accepted handshake, emitting R/G/B windows to the conv engine. Pulses
// row_done when the sweep ends and frame_done on the last row of a frame.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start                   : row triplet valid on the row inputs; begin sweep
//   R/G/B_row0..row2        : padded rows y-1, y, y+1 (PAD_W*DW each)
//   win_ready               : consumer accepts the current window
//   win_valid               : window outputs hold a valid window
//   win_R, win_G, win_B     : 3x3 window per channel, byte k = 3*r + c
//   win_col, win_row        : output coordinates of the current window
//   busy                    : sweep in progress
//   row_done                : one-cycle pulse after the last window is accepted
//   frame_done              : one-cycle pulse with row_done on row IMG_H-1
// -----------------------------------------------------------------------------
module conv_window_scanner #(
  parameter int  IMG_W = cnn_pkg::IMG_W,
  parameter int  IMG_H = cnn_pkg::IMG_H,
  parameter int  DW    = cnn_pkg::DW,
  localparam int PAD_W = IMG_W + 2,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PAD_W*DW-1:0] R_row0,
  input  logic [PAD_W*DW-1:0] G_row0,
  input  logic [PAD_W*DW-1:0] B_row0,
  input  logic [PAD_W*DW-1:0] R_row1,
  input  logic [PAD_W*DW-1:0] G_row1,
  input  logic [PAD_W*DW-1:0] B_row1,
  input  logic [PAD_W*DW-1:0] R_row2,
  input  logic [PAD_W*DW-1:0] G_row2,
  input  logic [PAD_W*DW-1:0] B_row2,
  input  logic                win_ready,
  output logic                win_valid,
  output logic [9*DW-1:0]     win_R,
  output logic [9*DW-1:0]     win_G,
  output logic [9*DW-1:0]     win_B,
  output logic [COL_W-1:0]    win_col,
  output logic [ROW_W-1:0]    win_row,
  output logic                busy,
  output logic                row_done,
  output logic                frame_done
);
  import cnn_pkg::*;

  logic [1:0]       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic             handshake;
  logic             last_col;
  logic             last_row;
  logic             load;
  logic [COL_W-1:0] load_col;
  logic [9*DW-1:0]  next_R;
  logic [9*DW-1:0]  next_G;
  logic [9*DW-1:0]  next_B;

  always_comb begin
    handshake = win_valid & win_ready;
    last_col  = (col == COL_W'(IMG_W - 1));
    last_row  = (row == ROW_W'(IMG_H - 1));
    // A sweep always begins at column 0; later loads take the column after
    // the one just accepted, so the slices look one step ahead.
    load_col  = (state == IDLE) ? '0 : col + COL_W'(1);
    load      = ((state == IDLE) && start) ||
                ((state == SCAN) && handshake && !last_col);
  end

  win_slice #(.PAD_W(PAD_W), .DW(DW), .XW(COL_W)) u_slice_r (
    .row0(R_row0), .row1(R_row1), .row2(R_row2), .x(load_col), .win(next_R)
  );

  win_slice #(.PAD_W(PAD_W), .DW(DW), .XW(COL_W)) u_slice_g (
    .row0(G_row0), .row1(G_row1), .row2(G_row2), .x(load_col), .win(next_G)
  );

  win_slice #(.PAD_W(PAD_W), .DW(DW), .XW(COL_W)) u_slice_b (
    .row0(B_row0), .row1(B_row1), .row2(B_row2), .x(load_col), .win(next_B)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_R      <= '0;
      win_G      <= '0;
      win_B      <= '0;
      win_col    <= '0;
      win_row    <= '0;
      busy       <= 1'b0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Pulses default low; the SCAN->DONE transition raises them for the
      // single DONE cycle.
      row_done   <= 1'b0;
      frame_done <= 1'b0;

      if (load) begin
        win_R   <= next_R;
        win_G   <= next_G;
        win_B   <= next_B;
        win_col <= load_col;
        win_row <= row;
        col     <= load_col;
      end

      case (state)
        IDLE: begin
          if (start) begin
            win_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (handshake && last_col) begin
            win_valid  <= 1'b0;
            busy       <= 1'b0;
            row_done   <= 1'b1;
            frame_done <= last_row;
            state      <= DONE;
          end
        end
        DONE: begin
          // start is not looked at here, so a start coincident with
          // row_done is dropped.
          col   <= '0;
          row   <= last_row ? '0 : row + ROW_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_scanner.sv
// -----------------------------------------------------------------------------
// tb_conv_window_scanner
// Self-checking bench. A full-size scanner is compared every cycle against a
// transaction-level model; a narrow, full-height instance covers frame wrap.
// -----------------------------------------------------------------------------
module tb_conv_window_scanner;
  import cnn_pkg::*;

  localparam int W   = IMG_W;
  localparam int H   = IMG_H;
  localparam int PW  = PAD_W;
  localparam int CW  = $clog2(W);
  localparam int RWD = $clog2(H);
  localparam int FW  = 4;     // frame-wrap instance width
  localparam int FH  = 416;   // frame-wrap instance height

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic              reset, start, win_ready;
  logic [PW*DW-1:0]  R_row0, G_row0, B_row0, R_row1, G_row1, B_row1;
  logic [PW*DW-1:0]  R_row2, G_row2, B_row2;
  logic              win_valid, busy, row_done, frame_done;
  logic [9*DW-1:0]   win_R, win_G, win_B;
  logic [CW-1:0]     win_col;
  logic [RWD-1:0]    win_row;

  conv_window_scanner dut (
    .clk(clk), .reset(reset), .start(start),
    .R_row0(R_row0), .G_row0(G_row0), .B_row0(B_row0),
    .R_row1(R_row1), .G_row1(G_row1), .B_row1(B_row1),
    .R_row2(R_row2), .G_row2(G_row2), .B_row2(B_row2),
    .win_ready(win_ready), .win_valid(win_valid),
    .win_R(win_R), .win_G(win_G), .win_B(win_B),
    .win_col(win_col), .win_row(win_row), .busy(busy),
    .row_done(row_done), .frame_done(frame_done)
  );

  // ---------------- frame-wrap DUT signals ----------------
  logic                 f_reset, f_start, f_ready;
  logic [(FW+2)*DW-1:0] f_rows;
  logic                 f_win_valid, f_busy, f_row_done, f_frame_done;
  logic [9*DW-1:0]      f_win_R, f_win_G, f_win_B;
  logic [1:0]           f_win_col;
  logic [8:0]           f_win_row;

  conv_window_scanner #(.IMG_W(FW), .IMG_H(FH), .DW(DW)) dut_f (
    .clk(clk), .reset(f_reset), .start(f_start),
    .R_row0(f_rows), .G_row0(f_rows), .B_row0(f_rows),
    .R_row1(f_rows), .G_row1(f_rows), .B_row1(f_rows),
    .R_row2(f_rows), .G_row2(f_rows), .B_row2(f_rows),
    .win_ready(f_ready), .win_valid(f_win_valid),
    .win_R(f_win_R), .win_G(f_win_G), .win_B(f_win_B),
    .win_col(f_win_col), .win_row(f_win_row), .busy(f_busy),
    .row_done(f_row_done), .frame_done(f_frame_done)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int seed     = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus picture: R is a ramp (r*16+p+seed) with the right pad pixel
  // forced to zero; G and B are unrelated patterns so channel mixups show.
  function automatic logic [7:0] pix(input int ch, input int r, input int p);
    case (ch)
      0:       return (p == PW-1) ? 8'h00 : 8'((r*16 + p + seed) & 255);
      1:       return 8'((p*3 + r*5 + seed) & 255);
      default: return 8'((255 - p + r*7 + seed*3) & 255);
    endcase
  endfunction

  task automatic load_rows();
    for (int p = 0; p < PW; p++) begin
      R_row0[DW*p +: DW] = pix(0, 0, p);
      R_row1[DW*p +: DW] = pix(0, 1, p);
      R_row2[DW*p +: DW] = pix(0, 2, p);
      G_row0[DW*p +: DW] = pix(1, 0, p);
      G_row1[DW*p +: DW] = pix(1, 1, p);
      G_row2[DW*p +: DW] = pix(1, 2, p);
      B_row0[DW*p +: DW] = pix(2, 0, p);
      B_row1[DW*p +: DW] = pix(2, 1, p);
      B_row2[DW*p +: DW] = pix(2, 2, p);
    end
  endtask

  function automatic logic [71:0] exp_win(input int ch, input int x);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = pix(ch, k/3, x + k%3);
    return w;
  endfunction

  // ---------------- transaction-level model ----------------
  // Tracks what the consumer must see: whether a window is on offer, which
  // column/row it is, the sweep flag and the end-of-row/frame pulses.
  bit m_valid, m_busy, m_rd, m_fd;
  int m_col, m_row, m_wcol, m_wrow;

  always @(posedge clk) begin
    bit in_done;
    if (reset) begin
      m_valid = 0; m_busy = 0; m_rd = 0; m_fd = 0;
      m_col = 0; m_row = 0; m_wcol = 0; m_wrow = 0;
    end else begin
      in_done = m_rd;
      m_rd = 0;
      m_fd = 0;
      if (in_done) begin
        // the row_done cycle: start is dropped
      end else if (!m_busy) begin
        if (start) begin
          m_valid = 1; m_busy = 1; m_col = 0; m_wcol = 0; m_wrow = m_row;
        end
      end else if (m_valid && win_ready) begin
        if (m_col == W-1) begin
          m_valid = 0; m_busy = 0; m_rd = 1;
          m_fd    = (m_row == H-1);
          m_row   = (m_row + 1) % H;
        end else begin
          m_col  = m_col + 1;
          m_wcol = m_col;
        end
      end
    end
  end

  // One compare process on the opposite clock edge.
  always @(negedge clk) begin
    check("win_valid",  win_valid,  m_valid);
    check("busy",       busy,       m_busy);
    check("row_done",   row_done,   m_rd);
    check("frame_done", frame_done, m_fd);
    check("win_col",    win_col,    m_wcol);
    check("win_row",    win_row,    m_wrow);
    if (m_valid) begin
      check("win_R", win_R, exp_win(0, m_wcol));
      check("win_G", win_G, exp_win(1, m_wcol));
      check("win_B", win_B, exp_win(2, m_wcol));
    end
  end

  int f_fd_count = 0;
  always @(negedge clk) if (!f_reset && f_frame_done) f_fd_count++;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sweep of the main DUT. ready_mod: win_ready high every ready_mod-th
  // cycle. spur_at: handshake count at which a stray start is raised.
  // rst_at: handshake count at which reset is applied (sweep abandoned).
  task automatic run_sweep(input int ready_mod, input int spur_at,
                           input int rst_at, input bit lit,
                           output int hs, output bit done_seen);
    int i;
    start = 1'b1;
    step();
    start = 1'b0;
    if (lit) begin
      check("first_valid", win_valid, 1'b1);
      check("col0_R", win_R, 72'h22_21_20_12_11_10_02_01_00);
    end
    hs = 0;
    i = 0;
    done_seen = 0;
    while (i < 4000) begin
      if (row_done) begin
        done_seen = 1;
        break;
      end
      if (hs == rst_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        break;
      end
      win_ready = ((i % ready_mod) == 0);
      start     = (hs == spur_at);
      if (win_valid && win_ready) begin
        if (lit && hs == W-1) begin
          check("last_col", win_col, 9'd415);
          check("last_R", win_R, 72'h00_C0_BF_00_B0_AF_00_A0_9F);
        end
        hs++;
      end
      step();
      i++;
    end
    start = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int  hs;
    bit  done_seen;
    int  k;

    reset = 1'b1; start = 1'b0; win_ready = 1'b0;
    f_reset = 1'b1; f_start = 1'b0; f_ready = 1'b0; f_rows = '0;
    seed = 0;
    load_rows();
    repeat (2) step();
    reset = 1'b0;
    f_reset = 1'b0;

    // Reset state
    check("rst_valid",  win_valid,  1'b0);
    check("rst_busy",   busy,       1'b0);
    check("rst_rd",     row_done,   1'b0);
    check("rst_fd",     frame_done, 1'b0);
    check("rst_R",      win_R,      72'h0);
    check("rst_col",    win_col,    9'd0);
    check("rst_row",    win_row,    9'd0);

    // Ramp, win_ready held high (row 0)
    run_sweep(1, -1, -1, 1'b1, hs, done_seen);
    check("ramp_hs", hs, 416);
    check("ramp_row_done", done_seen, 1'b1);
    step();

    // Back-pressure: ready 1,0,0,... (row 1)
    seed = 37;
    load_rows();
    run_sweep(3, -1, -1, 1'b0, hs, done_seen);
    check("bp_hs", hs, 416);
    check("bp_row_done", done_seen, 1'b1);
    step();

    // Spurious start at col 100 and during row_done (row 2)
    seed = 99;
    load_rows();
    run_sweep(1, 100, -1, 1'b0, hs, done_seen);
    check("spur_hs", hs, 416);
    check("spur_row_done", done_seen, 1'b1);
    start = 1'b1;                 // coincident with row_done: dropped
    step();
    start = 1'b0;
    check("spur_idle_valid", win_valid, 1'b0);
    step();
    check("spur_idle_busy", busy, 1'b0);
    check("spur_idle_valid2", win_valid, 1'b0);

    // Rows 3 and 4
    for (int r = 3; r < 5; r++) begin
      seed = r * 11;
      load_rows();
      run_sweep(1, -1, -1, 1'b0, hs, done_seen);
      check("fill_row_done", done_seen, 1'b1);
      step();
    end

    // Reset mid-sweep at col 200 on row 5
    seed = 200;
    load_rows();
    run_sweep(1, -1, 200, 1'b0, hs, done_seen);
    check("mid_rst_hs", hs, 200);
    check("mid_rst_valid", win_valid, 1'b0);
    check("mid_rst_busy",  busy,      1'b0);
    check("mid_rst_col",   win_col,   9'd0);
    check("mid_rst_row",   win_row,   9'd0);
    check("mid_rst_rd",    row_done,  1'b0);
    check("mid_rst_fd",    frame_done, 1'b0);
    step();
    check("mid_rst_rd2",   row_done,  1'b0);

    // Fresh sweep after reset starts again at row 0
    seed = 3;
    load_rows();
    start = 1'b1;
    step();
    start = 1'b0;
    check("post_rst_row", win_row, 9'd0);
    check("post_rst_col", win_col, 9'd0);
    run_sweep(1, -1, -1, 1'b0, hs, done_seen);
    step();

    // Frame wrap on the narrow, full-height instance
    f_ready = 1'b1;
    for (int r = 0; r < FH; r++) begin
      f_start = 1'b1;
      step();
      f_start = 1'b0;
      check("f_row", f_win_row, r);
      k = 0;
      while (!f_row_done && k < 20) begin
        step();
        k++;
      end
      check("f_row_done", f_row_done, 1'b1);
      check("f_frame_done", f_frame_done, (r == FH-1));
      step();
    end
    f_start = 1'b1;
    step();
    f_start = 1'b0;
    check("f_wrap_row",   f_win_row,   9'd0);
    check("f_wrap_valid", f_win_valid, 1'b1);
    check("f_fd_count",   f_fd_count,  1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
